// File: rtl/go_reg_pkg.sv
// go_reg shared definitions: FSM states, register map
// and bit positions used by the command/launch block.
package go_reg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_REPORT
    } state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_OPERAND = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CYCLES  = 2'd3;

    localparam int INT_COMPLETE = 0;
    localparam int INT_ERROR    = 1;
    localparam int INT_TIMEOUT  = 2;
    localparam int INT_OVERRUN  = 3;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_INT_EN = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_TMO  = 2;
    localparam int ST_OVR  = 3;

endpackage

// File: rtl/go_reg_timer.sv
// go_timer: saturating WAIT-cycle counter with clear,
// enable and a flag when the timeout threshold is reached.
module go_timer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // clear wins over enable; count sticks at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/go_reg.sv
// go_reg: CPU command register and accelerator launch
// sequencer producing the done/interrupt register write.
module go_reg
    import go_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_operand,
    input  logic              acc_done,
    input  logic              acc_err,
    output logic              done_we,
    output logic              done_d,
    output logic [3:0]        done_int
);

    state_e            state_q;
    logic              int_en_q, int_en_d;
    logic              ovr_q, ovr_d;
    logic              err_q, tmo_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              acc_start_q;
    logic              done_we_q, done_d_q;
    logic [3:0]        done_int_q;
    logic [3:0]        flags_raw, flags_d;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
    logic              busy, wr_ctrl, go;

    assign busy    = (state_q != S_IDLE);
    assign wr_ctrl = we && (addr == ADDR_CTRL);
    assign go      = wr_ctrl && wd[CTRL_GO];

    go_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q == S_START),
        .en_i  (state_q == S_WAIT),
        .cnt_o (cnt),
        .hit_o (hit)
    );

    // next values of the CPU-visible control bits
    always_comb begin
        int_en_d = wr_ctrl ? wd[CTRL_INT_EN] : int_en_q;
        ovr_d    = ovr_q;
        if (we && (addr == ADDR_STATUS)) ovr_d = 1'b0;
        if (go && busy) ovr_d = 1'b1;
    end

    // result flags for the REPORT write; done beats timeout
    always_comb begin
        flags_raw = '0;
        flags_raw[INT_OVERRUN] = ovr_d;
        if (acc_done) begin
            flags_raw[INT_COMPLETE] = 1'b1;
            flags_raw[INT_ERROR]    = acc_err;
        end else begin
            flags_raw[INT_TIMEOUT]  = 1'b1;
        end
    end

    assign flags_d = flags_raw & {4{int_en_d}};

    // read mux; rd holds its value between reads
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = '0;
            case (addr)
                ADDR_CTRL:    rd_d[CTRL_INT_EN] = int_en_q;
                ADDR_OPERAND: rd_d = operand_q;
                ADDR_STATUS: begin
                    rd_d[ST_BUSY] = busy;
                    rd_d[ST_ERR]  = err_q;
                    rd_d[ST_TMO]  = tmo_q;
                    rd_d[ST_OVR]  = ovr_q;
                end
                default:      rd_d = DATA_W'(cnt);
            endcase
        end
    end

    // CPU-writable registers and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            int_en_q  <= 1'b0;
            ovr_q     <= 1'b0;
            operand_q <= '0;
            rd_q      <= '0;
        end else begin
            int_en_q <= int_en_d;
            ovr_q    <= ovr_d;
            rd_q     <= rd_d;
            if (we && (addr == ADDR_OPERAND) && !busy) begin
                operand_q <= wd;
            end
        end
    end

    // launch sequencer with registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_start_q <= 1'b0;
            done_we_q   <= 1'b0;
            done_d_q    <= 1'b0;
            done_int_q  <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            acc_start_q <= 1'b0;
            done_we_q   <= 1'b0;
            done_d_q    <= 1'b0;
            done_int_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q     <= S_START;
                        acc_start_q <= 1'b1;
                        done_we_q   <= 1'b1;
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (acc_done || hit) begin
                        state_q    <= S_REPORT;
                        done_we_q  <= 1'b1;
                        done_d_q   <= 1'b1;
                        done_int_q <= flags_d;
                        err_q      <= flags_raw[INT_ERROR];
                        tmo_q      <= flags_raw[INT_TIMEOUT];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd          = rd_q;
    assign acc_start   = acc_start_q;
    assign acc_operand = operand_q;
    assign done_we     = done_we_q;
    assign done_d      = done_d_q;
    assign done_int    = done_int_q;

endmodule

// File: tb/tb_go_reg.sv
// tb_go_reg: scenario tasks plus randomized runs checked
// against a run-level model of the launch sequencer.
module tb_go_reg;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [DW-1:0] wd = '0;
    logic          acc_done = 1'b0;
    logic          acc_err = 1'b0;
    logic [DW-1:0] rd;
    logic          acc_start;
    logic [DW-1:0] acc_operand;
    logic          done_we;
    logic          done_d;
    logic [3:0]    done_int;

    int n_cmp = 0;
    int n_bad = 0;

    // run-level model state
    logic          m_int_en = 1'b0;
    logic          m_ovr = 1'b0;
    logic          m_err = 1'b0;
    logic          m_tmo = 1'b0;
    logic [DW-1:0] m_op = '0;
    int            m_cyc = 0;

    go_reg #(
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .re          (re),
        .addr        (addr),
        .wd          (wd),
        .rd          (rd),
        .acc_start   (acc_start),
        .acc_operand (acc_operand),
        .acc_done    (acc_done),
        .acc_err     (acc_err),
        .done_we     (done_we),
        .done_d      (done_d),
        .done_int    (done_int)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrreg(input logic [1:0] a, input logic [DW-1:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [DW-1:0] v);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        v    = rd;
    endtask

    function automatic int rep_of(input int d);
        return 1 + ((d <= TO) ? d : TO);
    endfunction

    function automatic logic [DW-1:0] status_exp();
        return DW'({m_ovr, m_tmo, m_err, 1'b0});
    endfunction

    // One launch: delay = cycles from acc_start to acc_done
    // (beyond TO means the accelerator never answers).
    task automatic run(input logic ien, input int delay,
                       input logic err, input int gok,
                       input int opk, input bit do_rd,
                       input string nm);
        int            rk;
        bit            done_ok;
        logic [3:0]    exp;
        logic [DW-1:0] v;
        rk      = rep_of(delay);
        done_ok = (delay <= TO);
        m_int_en = ien;
        wrreg(2'd0, DW'({ien, 1'b1}));
        n_cmp++;
        if ({acc_start, done_we, done_d, done_int} !== 7'b1100000) begin
            n_bad++;
            $display("FAIL %s_start: got %b want 1100000", nm,
                     {acc_start, done_we, done_d, done_int});
        end
        acc_done = 1'($urandom % 2);
        acc_err  = 1'($urandom % 2);
        for (int k = 1; k <= rk + 1; k++) begin
            tick();
            acc_done = 1'b0;
            acc_err  = 1'b0;
            we       = 1'b0;
            if (k == rk) begin
                exp = {m_ovr, !done_ok, done_ok && err, done_ok};
                exp = exp & {4{m_int_en}};
                n_cmp++;
                if ({acc_start, done_we, done_d, done_int} !== {3'b011, exp}) begin
                    n_bad++;
                    $display("FAIL %s_report k=%0d: got %b want %b", nm, k,
                             {acc_start, done_we, done_d, done_int},
                             {3'b011, exp});
                end
            end else begin
                n_cmp++;
                if ({acc_start, done_we} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL %s_quiet k=%0d: got %b want 00", nm, k,
                             {acc_start, done_we});
                end
            end
            n_cmp++;
            if (acc_operand !== m_op) begin
                n_bad++;
                $display("FAIL %s_operand k=%0d: got %h want %h", nm, k,
                         acc_operand, m_op);
            end
            if (k < rk) begin
                if (done_ok && k == delay) begin
                    acc_done = 1'b1;
                    acc_err  = err;
                end else begin
                    acc_err  = 1'($urandom % 2);
                end
                if (k == gok) begin
                    addr  = 2'd0;
                    wd    = DW'({m_int_en, 1'b1});
                    we    = 1'b1;
                    m_ovr = 1'b1;
                end else if (k == opk) begin
                    addr = 2'd1;
                    wd   = $urandom;
                    we   = 1'b1;
                end
            end
        end
        m_err = done_ok && err;
        m_tmo = !done_ok;
        m_cyc = done_ok ? delay : TO;
        if (do_rd) begin
            rdreg(2'd2, v);
            n_cmp++;
            if (v !== status_exp()) begin
                n_bad++;
                $display("FAIL %s_status: got %h want %h", nm, v, status_exp());
            end
            rdreg(2'd3, v);
            n_cmp++;
            if (v !== DW'(m_cyc)) begin
                n_bad++;
                $display("FAIL %s_cycles: got %0d want %0d", nm, v, m_cyc);
            end
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({rd, acc_start, acc_operand, done_we, done_d, done_int} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rd, acc_start, acc_operand, done_we, done_d, done_int});
        end
        rst = 1'b0;
        tick();
        rdreg(2'd2, v);
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_status: got %h want 0", v);
        end
        rdreg(2'd0, v);
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h want 0", v);
        end
        rdreg(2'd3, v);
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_cycles: got %h want 0", v);
        end
    endtask

    task automatic test_complete();
        logic [DW-1:0] v;
        v = 32'hA5A5_0001;
        wrreg(2'd1, v);
        m_op = v;
        rdreg(2'd1, v);
        n_cmp++;
        if (v !== m_op) begin
            n_bad++;
            $display("FAIL operand_read: got %h want %h", v, m_op);
        end
        run(1'b1, 5, 1'b0, 0, 0, 1'b1, "complete");
        repeat (2) tick();
        n_cmp++;
        if (rd !== DW'(m_cyc)) begin
            n_bad++;
            $display("FAIL rd_hold: got %0d want %0d", rd, m_cyc);
        end
    endtask

    task automatic test_timeout();
        run(1'b1, TO + 5, 1'b0, 0, 0, 1'b1, "timeout");
    endtask

    task automatic test_err_noint();
        run(1'b0, 3, 1'b1, 0, 0, 1'b1, "err_noint");
    endtask

    task automatic test_overrun();
        logic [DW-1:0] v;
        run(1'b1, 4, 1'b0, 2, 3, 1'b1, "overrun");
        addr = 2'd2;
        wd   = '0;
        we   = 1'b1;
        re   = 1'b1;
        tick();
        we   = 1'b0;
        re   = 1'b0;
        n_cmp++;
        if (rd !== status_exp()) begin
            n_bad++;
            $display("FAIL rw_same_cycle: got %h want %h", rd, status_exp());
        end
        m_ovr = 1'b0;
        rdreg(2'd2, v);
        n_cmp++;
        if (v !== status_exp()) begin
            n_bad++;
            $display("FAIL overrun_clear: got %h want %h", v, status_exp());
        end
    endtask

    task automatic test_coincide();
        run(1'b1, TO, 1'b0, 0, 0, 1'b1, "coincide");
    endtask

    task automatic test_back_to_back();
        run(1'b1, 2, 1'b1, 0, 0, 1'b0, "b2b_a");
        run(1'b1, 1, 1'b0, 0, 0, 1'b1, "b2b_b");
    endtask

    task automatic test_random();
        int            d, rk, gk, ok;
        logic [DW-1:0] v;
        for (int i = 0; i < 30; i++) begin
            if ($urandom % 2) begin
                v = $urandom;
                wrreg(2'd1, v);
                m_op = v;
            end
            if (m_ovr && ($urandom % 2)) begin
                wrreg(2'd2, '0);
                m_ovr = 1'b0;
            end
            d  = $urandom_range(1, TO + 3);
            rk = rep_of(d);
            gk = ($urandom % 3 == 0) ? $urandom_range(1, rk - 1) : 0;
            ok = ($urandom % 2) ? $urandom_range(1, rk - 1) : 0;
            if (ok == gk) ok = 0;
            run(1'($urandom % 2), d, 1'($urandom % 2), gk, ok,
                1'($urandom % 2), "random");
        end
    endtask

    task automatic test_reset_midrun();
        logic [DW-1:0] v;
        wrreg(2'd0, 32'h3);
        tick();
        wrreg(2'd0, 32'h3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_int_en = 1'b0;
        m_ovr    = 1'b0;
        m_err    = 1'b0;
        m_tmo    = 1'b0;
        m_op     = '0;
        n_cmp++;
        if ({rd, acc_start, acc_operand, done_we, done_d, done_int} !== '0) begin
            n_bad++;
            $display("FAIL midrun_outputs: got %h want 0",
                     {rd, acc_start, acc_operand, done_we, done_d, done_int});
        end
        acc_done = 1'b1;
        acc_err  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            acc_done = 1'b0;
            acc_err  = 1'b0;
            n_cmp++;
            if ({acc_start, done_we, done_d, done_int} !== 7'b0) begin
                n_bad++;
                $display("FAIL midrun_quiet k=%0d: got %b want 0", k,
                         {acc_start, done_we, done_d, done_int});
            end
        end
        rdreg(2'd2, v);
        n_cmp++;
        if (v !== status_exp()) begin
            n_bad++;
            $display("FAIL midrun_status: got %h want %h", v, status_exp());
        end
    endtask

    initial begin
        test_reset();
        test_complete();
        test_timeout();
        test_err_noint();
        test_overrun();
        test_coincide();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
